// File: rtl/decode_pipe.sv
// Instruction decode stage: decodes at enqueue into a DEPTH-entry circular FIFO.
// Optional macro FPU_DECODE_EN adds decode of the single-precision load/store/op opcodes.
module decode_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [11:0]     out_ctrl,
  output logic            out_illegal,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [PC_W-1:0] out_pc,
  output logic [7:0]      illegal_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic       fpu_en;
    logic       mul_en;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] jump;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic            illegal;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [PC_W-1:0] pc;
  } entry_t;

  // Opcode constants
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
`ifdef FPU_DECODE_EN
  localparam logic [6:0] OpFload  = 7'b0000111;
  localparam logic [6:0] OpFstore = 7'b0100111;
  localparam logic [6:0] OpFp     = 7'b1010011;
`endif

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [6:0] funct7;
  ctrl_t      dec_ctrl;
  logic       dec_illegal;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OpReg: begin
          if (funct7 == F7Base || funct7 == F7Alt || funct7 == F7Mul) begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = 2'b10;
            dec_ctrl.mul_en    = (funct7 == F7Mul);
          end else begin
            dec_illegal = 1'b1;
          end
        end
        OpImm: begin
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.alu_op    = 2'b10;
        end
        OpLoad: begin
          dec_ctrl.mem_read   = 1'b1;
          dec_ctrl.mem_to_reg = 1'b1;
          dec_ctrl.alu_src    = 1'b1;
          dec_ctrl.reg_write  = 1'b1;
        end
        OpStore: begin
          dec_ctrl.mem_write = 1'b1;
          dec_ctrl.alu_src   = 1'b1;
        end
        OpBranch: begin
          dec_ctrl.branch = 1'b1;
          dec_ctrl.alu_op = 2'b01;
        end
        OpJal: begin
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.jump      = 2'b10;
        end
        OpJalr: begin
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.jump      = 2'b01;
        end
        OpLui, OpAuipc: begin
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.alu_op    = 2'b11;
        end
`ifdef FPU_DECODE_EN
        OpFload: begin
          dec_ctrl.fpu_en     = 1'b1;
          dec_ctrl.mem_read   = 1'b1;
          dec_ctrl.mem_to_reg = 1'b1;
          dec_ctrl.alu_src    = 1'b1;
          dec_ctrl.reg_write  = 1'b1;
        end
        OpFstore: begin
          dec_ctrl.fpu_en    = 1'b1;
          dec_ctrl.mem_write = 1'b1;
          dec_ctrl.alu_src   = 1'b1;
        end
        OpFp: begin
          dec_ctrl.fpu_en    = 1'b1;
          dec_ctrl.reg_write = 1'b1;
        end
`endif
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  entry_t wr_entry;

  always_comb begin
    wr_entry         = '0;
    wr_entry.ctrl    = dec_ctrl;
    wr_entry.illegal = dec_illegal;
    wr_entry.rd      = in_instr[11:7];
    wr_entry.rs1     = in_instr[19:15];
    wr_entry.rs2     = in_instr[24:20];
    wr_entry.funct3  = in_instr[14:12];
    wr_entry.pc      = in_pc;
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      illegal_cnt_q, illegal_cnt_d;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Gating on rst keeps the handshake quiet while the synchronous reset is pending.
  assign in_ready  = !rst && !full && !flush;
  assign out_valid = !rst && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    if (push && dec_illegal && illegal_cnt_q != 8'hFF) begin
      illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Storage is not reset; entries are only observable through the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs, zeroed when nothing is valid
  // ---------------------------------------------------------------------------
  entry_t head;

  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign out_ctrl    = head.ctrl;
  assign out_illegal = head.illegal;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_funct3  = head.funct3;
  assign out_pc      = head.pc;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: table-driven decode vectors plus
// hand-written FIFO full/flush/saturation sequences.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_ctrl;
  logic        out_illegal;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [31:0] out_pc;
  logic [7:0]  illegal_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  decode_pipe #(.DEPTH(2), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_illegal(out_illegal),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_funct3 (out_funct3),
    .out_pc     (out_pc),
    .illegal_cnt(illegal_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [11:0] ctrl;
    logic        ill;
  } vec_t;

  localparam int NumVec = 17;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  initial begin
    vecs[0]  = '{32'h00A00093, 12'h032, 1'b0};  // addi
    vecs[1]  = '{32'h02B50533, 12'h412, 1'b0};  // mul
    vecs[2]  = '{32'h00B50533, 12'h012, 1'b0};  // add
    vecs[3]  = '{32'h40B50533, 12'h012, 1'b0};  // sub
    vecs[4]  = '{32'h04B50533, 12'h000, 1'b1};  // bad funct7
    vecs[5]  = '{32'h0000A083, 12'h1B0, 1'b0};  // lw
    vecs[6]  = '{32'h00112023, 12'h060, 1'b0};  // sw
    vecs[7]  = '{32'h00B50463, 12'h201, 1'b0};  // beq
    vecs[8]  = '{32'h008000EF, 12'h018, 1'b0};  // jal
    vecs[9]  = '{32'h000080E7, 12'h034, 1'b0};  // jalr
    vecs[10] = '{32'h000010B7, 12'h033, 1'b0};  // lui
    vecs[11] = '{32'h00001097, 12'h033, 1'b0};  // auipc
    vecs[12] = '{32'hFFFFFFFF, 12'h000, 1'b1};  // unlisted opcode
    vecs[13] = '{32'h00A00090, 12'h000, 1'b1};  // instr[1:0] != 11
`ifdef FPU_DECODE_EN
    vecs[14] = '{32'h0000A087, 12'h9B0, 1'b0};  // flw
    vecs[15] = '{32'h0000A027, 12'h860, 1'b0};  // fsw
    vecs[16] = '{32'h00000053, 12'h810, 1'b0};  // fadd.s
`else
    vecs[14] = '{32'h0000A087, 12'h000, 1'b1};
    vecs[15] = '{32'h0000A027, 12'h000, 1'b1};
    vecs[16] = '{32'h00000053, 12'h000, 1'b1};
`endif

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_illegal_cnt", {24'b0, illegal_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Decode table: push one, check head next cycle, pop it.
    for (int i = 0; i < NumVec; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(i) * 4;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d_ctrl", i), {20'b0, out_ctrl}, {20'b0, vecs[i].ctrl});
      check($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      check($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].instr[11:7]});
      check($sformatf("v%0d_rs1", i), {27'b0, out_rs1}, {27'b0, vecs[i].instr[19:15]});
      check($sformatf("v%0d_rs2", i), {27'b0, out_rs2}, {27'b0, vecs[i].instr[24:20]});
      check($sformatf("v%0d_funct3", i), {29'b0, out_funct3}, {29'b0, vecs[i].instr[14:12]});
      check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 4);
      if (vecs[i].ill) exp_cnt = sat_inc(exp_cnt);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'd0);
      check($sformatf("v%0d_zero_ctrl", i), {20'b0, out_ctrl}, 32'd0);
    end
    check("table_illegal_cnt", {24'b0, illegal_cnt}, 32'(exp_cnt));

    // Fill to DEPTH with consumer stalled.
    in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'hA0; tick();
    check("fill1_in_ready", {31'b0, in_ready}, 32'd1);
    in_instr = 32'h00B50533; in_pc = 32'hB0; tick();
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_instr = 32'h000010B7; in_pc = 32'hC0; tick();
    check("full_head_pc", out_pc, 32'hA0);
    check("full_still_blocked", {31'b0, in_ready}, 32'd0);
    // Push and pop together while full: only the pop happens.
    out_ready = 1'b1; tick();
    check("fullpp_head_pc", out_pc, 32'hB0);
    check("fullpp_ctrl", {20'b0, out_ctrl}, 32'h012);
    check("fullpp_count1_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0; tick();
    check("third_never_accepted", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Push+pop with one entry keeps the count (and exercises wrap).
    in_valid = 1'b1; in_instr = 32'h00112023; in_pc = 32'hD0; tick();
    in_instr = 32'h00B50463; in_pc = 32'hE0; out_ready = 1'b1; tick();
    check("pp_head_pc", out_pc, 32'hE0);
    check("pp_valid", {31'b0, out_valid}, 32'd1);
    check("pp_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0; tick();
    check("pp_drained", {31'b0, out_valid}, 32'd0);

    // 300 illegal pushes saturate the counter.
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_pc = 32'(i);
      tick();
      exp_cnt = sat_inc(exp_cnt);
      check($sformatf("sat%0d_illegal", i), {31'b0, out_valid & out_illegal}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("sat_cnt", {24'b0, illegal_cnt}, 32'(exp_cnt));
    check("sat_cnt_255", {24'b0, illegal_cnt}, 32'd255);
    check("preflush_valid", {31'b0, out_valid}, 32'd1);

    // Flush with a concurrent push attempt.
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF; out_ready = 1'b1;
    #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_keeps_cnt", {24'b0, illegal_cnt}, 32'd255);

    // Reset mid-operation discards entries and clears the counter.
    in_valid = 1'b1; in_instr = 32'h00A00093; tick();
    in_valid = 1'b0;
    check("midrst_pre_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1; #1;
    check("midrst_during_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b0; #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_cnt", {24'b0, illegal_cnt}, 32'd0);
    check("midrst_ready", {31'b0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The module SHALL use one clock and one reset: clock `clk`, reset `rst`, synchronous, active-high.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving buffer entries (power of two, 2..16).
REQ-003 The module SHALL have parameter PC_W, default 32, giving the program-counter width.
REQ-004 The module SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  buffer can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- flush  in  1  discard all buffered entries
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_ctrl  out  12  {fpu_en, mul_en, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump[1:0], alu_op[1:0]}
- out_illegal  out  1  unsupported encoding
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- out_funct3  out  3  instr[14:12]
- out_pc  out  PC_W  pass-through address
- illegal_cnt  out  8  saturating illegal-instruction count

Function
REQ-005 The module SHALL decode at enqueue and store the decoded bundle in a DEPTH-entry circular FIFO; outputs SHALL come only from the head entry.
REQ-006 The module SHALL accept an entry when in_valid && in_ready, and SHALL drive in_ready = !full && !flush.
REQ-007 The module SHALL pop the head when out_valid && out_ready, and SHALL drive out_valid = !empty.
REQ-008 The module SHALL assert out_valid in the cycle after an accept into an empty FIFO (latency 1).
REQ-009 The module SHALL perform a simultaneous push and pop with the count unchanged; when full, in_ready is low even if a pop occurs.
REQ-010 The module SHALL wrap read and write pointers modulo DEPTH.
REQ-011 On flush, the module SHALL empty the FIFO at the next edge and ignore any push or pop in that cycle.
REQ-012 The module SHALL decode out_ctrl per opcode instr[6:0]; unlisted bits are 0:
- 0110011: reg_write, alu_op=10, plus mul_en when funct7=0000001
- 0010011: alu_src, reg_write, alu_op=10
- 0000011: mem_read, mem_to_reg, alu_src, reg_write
- 0100011: mem_write, alu_src
- 1100011: branch, alu_op=01
- 1101111: reg_write, jump=10
- 1100111: alu_src, reg_write, jump=01
- 0110111 and 0010111: alu_src, reg_write, alu_op=11
REQ-013 The module SHALL set out_illegal, with out_ctrl all zero, for unlisted opcodes, for instr[1:0]!=11, and for opcode 0110011 with funct7 other than 0000000, 0100000 or 0000001.
REQ-014 The module SHALL increment illegal_cnt on each accepted illegal instruction, saturating at 255; a flush SHALL NOT clear it.

Reset
REQ-015 During reset, the module SHALL set pointers and count to 0, out_valid 0, in_ready 0, and illegal_cnt 0.
REQ-016 In the first cycle after reset, the module SHALL have in_ready 1.
REQ-017 Reset mid-operation SHALL discard all entries; the FIFO storage contents SHALL be don't-care.
REQ-018 When out_valid is 0, the module SHALL drive out_ctrl, out_illegal and the field outputs to 0.

Configuration
REQ-019 The module SHALL support macro FPU_DECODE_EN.
- Defined: 0000111 decodes to fpu_en, mem_read, mem_to_reg, alu_src, reg_write; 0100111 decodes to fpu_en, mem_write, alu_src; 1010011 decodes to fpu_en, reg_write.
- Undefined: these three opcodes are illegal and fpu_en is constant 0.

Verification
REQ-020 The bench SHALL check: reset, then push 0x00A00093 (addi) -> next cycle out_valid=1, out_ctrl=12'h032, out_rd=1.
REQ-021 The bench SHALL check: push 0x02B50533 (mul) -> mul_en=1, reg_write=1, alu_op=10, out_illegal=0.
REQ-022 The bench SHALL check: out_ready=0 with DEPTH=2 pushes -> in_ready=0 after 2 accepts; a third in_valid is not accepted; then drain order is preserved.
REQ-023 The bench SHALL check: full FIFO with push and pop asserted the same cycle -> only the pop occurs, count goes 2->1.
REQ-024 The bench SHALL check: 300 pushes of 0xFFFFFFFF -> out_illegal=1 each and illegal_cnt=255; flush -> out_valid=0 next cycle and illegal_cnt stays 255.
REQ-025 The bench SHALL check: push 0x0000A087 (flw) -> fpu_en=1 with FPU_DECODE_EN defined, out_illegal=1 without it.
